// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings
// and the default operand width.
package div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor, and keep the difference only when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Subtract one bit wider than R so the top bit of trial is the borrow.
  always_comb begin
    shifted = {r, q[WIDTH-1]};
    trial   = shifted - {2'b00, divisor};
    if (trial[WIDTH+1]) begin
      r_next = shifted[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end else begin
      r_next = trial[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider with start/busy/done handshake.
// Produces one quotient bit per clock; results hold until the next completion.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH:0]   r, r_next;
  logic [WIDTH-1:0] q, q_next, divisor_r;
  logic [CW-1:0]    count;
  logic             zero_pend;
  logic             accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .q      (q),
    .divisor(divisor_r),
    .r_next (r_next),
    .q_next (q_next)
  );

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // A zero divisor waits one idle cycle in zero_pend so its result lands one edge after acceptance.
  always_comb begin
    accept     = 1'b0;
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (zero_pend) begin
          state_next = S_DONE;
        end else if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? S_IDLE : S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (count == LAST) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // The working quotient register doubles as the latched dividend for the zero-divisor result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      q           <= '0;
      divisor_r   <= '0;
      count       <= '0;
      zero_pend   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      r         <= '0;
      q         <= dividend;
      divisor_r <= divisor;
      count     <= '0;
      zero_pend <= (divisor == '0);
    end else if (zero_pend) begin
      zero_pend   <= 1'b0;
      quotient    <= '1;
      remainder   <= q;
      div_by_zero <= 1'b1;
    end else if (state == S_RUN) begin
      r     <= r_next;
      q     <= q_next;
      count <= count + 1'b1;
      if (count == LAST) begin
        quotient    <= q_next;
        remainder   <= r_next[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
